// File: rtl/word_pair_packer_pkg.sv
// Shared definitions for the word pair packer: FSM state encoding and width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package word_pair_packer_pkg;

   // Half-full flag encoding: EMPTY holds no pending word, HALF holds the first word of a pair.
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_HALF  = 1'b1;

   // Width of a packed output word built from two input words.
   function automatic int double_width(input int width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/word_pair_packer_pack_out_slot.sv
// pack_out_slot: registered DW-bit output slot with valid/ready hold and load/drain arbitration.
// Latency: load_vld in cycle N gives out_valid/out_data in cycle N+1.
// Backpressure: while out_valid && !out_ready the slot holds; slot_free tells the producer when a load is allowed.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   load_vld, load_dat  load request from the producer; only asserted while slot_free
//   slot_free           slot empty or being drained this cycle
//   out_valid/out_ready/out_data  downstream valid/ready stream
module pack_out_slot #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_vld,
   input  logic [DW-1:0] load_dat,
   output logic          slot_free,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   assign slot_free = !valid_q || out_ready;
   assign out_valid = valid_q;
   assign out_data  = data_q;

   // A load in the same cycle as a drain replaces the word and keeps valid high (no bubble).
   // A drain without a load clears valid but keeps the last data.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_vld) begin
         valid_d = 1'b1;
         data_d  = load_dat;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/word_pair_packer.sv
// word_pair_packer: packs two consecutive WIDTH-bit stream words into one 2*WIDTH-bit word.
// Latency: out_valid rises the cycle after the second word of a pair is accepted; one word/cycle sustained.
// Backpressure: first word of a pair is always accepted; the second waits until the output slot is free.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data       WIDTH-bit input stream
//   out_valid/out_ready/out_data    2*WIDTH-bit packed output stream
//   flush, out_partial              only with PACKER_FLUSH_EN: emit a lone half word zero-padded
// Optional feature macro: PACKER_FLUSH_EN
module word_pair_packer
   import word_pair_packer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int LSB_FIRST = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [double_width(WIDTH)-1:0] out_data
`ifdef PACKER_FLUSH_EN
   ,
   input  logic                           flush,
   output logic                           out_partial
`endif
);

   localparam int DW = double_width(WIDTH);

   logic             state_q, state_d;
   logic [WIDTH-1:0] half_q, half_d;
   logic             slot_free;
   logic             in_fire;
   logic             flush_req;
   logic             flush_load;
   logic             load_vld;
   logic [DW-1:0]    load_dat;

`ifdef PACKER_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         half_q  <= '0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               half_d  = in_data;
               state_d = ST_HALF;
            end
         end
         default: begin
            if (in_fire || flush_load) begin
               state_d = ST_EMPTY;
            end
         end
      endcase
   end

   // Output logic: handshake and slot load requests
   always_comb begin
      // In HALF a pending flush blocks the second word so the half word leaves alone.
      in_ready   = !reset && ((state_q == ST_EMPTY) || (slot_free && !flush_req));
      in_fire    = in_valid && in_ready;
      flush_load = !reset && (state_q == ST_HALF) && flush_req && slot_free;
      load_vld   = (in_fire && (state_q == ST_HALF)) || flush_load;
      load_dat   = '0;
      if (LSB_FIRST != 0) begin
         load_dat = flush_load ? {{WIDTH{1'b0}}, half_q} : {in_data, half_q};
      end else begin
         load_dat = flush_load ? {half_q, {WIDTH{1'b0}}} : {half_q, in_data};
      end
   end

   pack_out_slot #(
      .DW(DW)
   ) u_out_slot (
      .clk       (clk),
      .reset     (reset),
      .load_vld  (load_vld),
      .load_dat  (load_dat),
      .slot_free (slot_free),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

`ifdef PACKER_FLUSH_EN
   logic partial_q, partial_d;

   // Tag travels with the slot contents: only rewritten on a load.
   always_comb begin
      partial_d = partial_q;
      if (load_vld) begin
         partial_d = flush_load;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         partial_q <= 1'b0;
      end else begin
         partial_q <= partial_d;
      end
   end

   assign out_partial = partial_q;
`endif

endmodule

// File: tb/tb_word_pair_packer.sv
module tb_word_pair_packer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   logic        m_in_valid;
   logic        m_in_ready;
   logic [7:0]  m_in_data;
   logic        m_out_valid;
   logic        m_out_ready;
   logic [15:0] m_out_data;

`ifdef PACKER_FLUSH_EN
   logic flush;
   logic out_partial;
   logic m_flush;
   logic m_out_partial;
`endif

   int tests;
   int fails;

   word_pair_packer #(.WIDTH(8), .LSB_FIRST(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PACKER_FLUSH_EN
      ,
      .flush       (flush),
      .out_partial (out_partial)
`endif
   );

   word_pair_packer #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (m_in_valid),
      .in_ready  (m_in_ready),
      .in_data   (m_in_data),
      .out_valid (m_out_valid),
      .out_ready (m_out_ready),
      .out_data  (m_out_data)
`ifdef PACKER_FLUSH_EN
      ,
      .flush       (m_flush),
      .out_partial (m_out_partial)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_hold[%0d]: in_ready=%b out_valid=%b out_data=%h, required 0 0 0000",
                     i, in_ready, out_valid, out_data);
         end
         tick();
      end
      reset = 1'b0; in_valid = 1'b0;
      tick();
   endtask

   task automatic test_streaming();
      logic [7:0] words [4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = words[i];
         #1;
         tests++;
         if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stream_in_ready[%0d]: got %b, required 1", i, in_ready);
         end
         tick();
         tests++;
         case (i)
            0: if (out_valid !== 1'b0) begin
                  fails++; $display("FAIL stream_after_w0: out_valid=%b, required 0", out_valid);
               end
            1: if (out_valid !== 1'b1 || out_data !== 16'h2211) begin
                  fails++; $display("FAIL stream_pair0: out_valid=%b out_data=%h, required 1 2211", out_valid, out_data);
               end
            2: if (out_valid !== 1'b0 || out_data !== 16'h2211) begin
                  fails++; $display("FAIL stream_drained: out_valid=%b out_data=%h, required 0 2211 (held)", out_valid, out_data);
               end
            default: if (out_valid !== 1'b1 || out_data !== 16'h4433) begin
                  fails++; $display("FAIL stream_pair1: out_valid=%b out_data=%h, required 1 4433", out_valid, out_data);
               end
         endcase
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL stream_idle: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h2211) begin
         fails++; $display("FAIL bp_first: out_valid=%b out_data=%h, required 1 2211", out_valid, out_data);
      end
      in_data = 8'h33;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_accept_half: in_ready=%b, required 1", in_ready);
      end
      tick();
      in_data = 8'h44;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_stall: in_ready=%b, required 0", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h2211) begin
         fails++; $display("FAIL bp_hold: out_valid=%b out_data=%h, required 1 2211", out_valid, out_data);
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h4433) begin
         fails++; $display("FAIL bp_no_bubble: out_valid=%b out_data=%h, required 1 4433", out_valid, out_data);
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL bp_drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'hAA; tick();
      in_valid = 1'b0; reset = 1'b1; tick();
      reset = 1'b0;
      in_valid = 1'b1; in_data = 8'hBB; tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL midrst_after_bb: out_valid=%b out_data=%h, required 0", out_valid, out_data);
      end
      in_data = 8'hCC; tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'hCCBB) begin
         fails++; $display("FAIL midrst_pair: out_valid=%b out_data=%h, required 1 ccbb", out_valid, out_data);
      end
      in_valid = 1'b0; tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL midrst_single: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_gap_hold();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h55; tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL gap_idle: out_valid=%b, required 0", out_valid);
      end
      in_valid = 1'b1; in_data = 8'h66; tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h6655) begin
         fails++; $display("FAIL gap_pair: out_valid=%b out_data=%h, required 1 6655", out_valid, out_data);
      end
      in_valid = 1'b0; tick();
   endtask

   task automatic test_msb_first();
      m_out_ready = 1'b1;
      m_in_valid = 1'b1; m_in_data = 8'h11; tick();
      m_in_data = 8'h22; tick();
      tests++;
      if (m_out_valid !== 1'b1 || m_out_data !== 16'h1122) begin
         fails++; $display("FAIL msb_first: out_valid=%b out_data=%h, required 1 1122", m_out_valid, m_out_data);
      end
      m_in_valid = 1'b0; tick();
   endtask

`ifdef PACKER_FLUSH_EN
   task automatic test_flush();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h5A; tick();
      in_valid = 1'b0; flush = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL flush_blocks_input: in_ready=%b, required 0", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h005A || out_partial !== 1'b1) begin
         fails++; $display("FAIL flush_partial: v=%b d=%h p=%b, required 1 005a 1", out_valid, out_data, out_partial);
      end
      tick();
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_empty: out_valid=%b, required 0", out_valid);
      end
      flush = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      in_data = 8'h33; tick();
      in_valid = 1'b0; flush = 1'b1; tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h2211 || out_partial !== 1'b0) begin
         fails++; $display("FAIL flush_held: v=%b d=%h p=%b, required 1 2211 0", out_valid, out_data, out_partial);
      end
      out_ready = 1'b1; tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h0033 || out_partial !== 1'b1) begin
         fails++; $display("FAIL flush_after_ready: v=%b d=%h p=%b, required 1 0033 1", out_valid, out_data, out_partial);
      end
      flush = 1'b0; tick();
   endtask
`endif

   initial begin
      tests = 0; fails = 0;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
      flush = 1'b0; m_flush = 1'b0;
`endif
      test_reset();
      test_streaming();
      test_backpressure();
      test_mid_reset();
      test_gap_hold();
      test_msb_first();
`ifdef PACKER_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
